// File: rtl/apb_arb_pkg.sv
// Shared types and default constants for the APB master arbiter.
// The optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  localparam int MST_C_DEF = 2;
  localparam int TMO_C_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin grant logic with the last-grant pointer; the pointer moves only
// on upd_i, to the index carried by the committed one-hot grant upd_gnt_i.
module apb_rr_arb
  import apb_arb_pkg::*;
#(
  parameter int mst_c = MST_C_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [mst_c-1:0] req_i,
  input  logic             upd_i,
  input  logic [mst_c-1:0] upd_gnt_i,
  output logic [mst_c-1:0] gnt_o
);

  localparam int IW = (mst_c > 1) ? $clog2(mst_c) : 1;

  logic [IW-1:0] last_q, last_d;
  logic          found;

  // Search starts one past the last served master and wraps around.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 1; i <= mst_c; i++) begin
      for (int k = 0; k < mst_c; k++) begin
        if (!found && req_i[k] && (((int'(last_q) + i) % mst_c) == k)) begin
          gnt_o[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      for (int k = 0; k < mst_c; k++) begin
        if (upd_gnt_i[k]) last_d = IW'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= IW'(mst_c - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-master to single APB master bridge with round-robin arbitration.
// Define APB_ARB_TIMEOUT_EN to add an ACCESS-phase timeout that completes with err_m.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int mst_c = MST_C_DEF,
  parameter int a_w   = 8,
  parameter int tmo_c = TMO_C_DEF
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [mst_c-1:0][0:0]      req_m,
  input  logic [mst_c-1:0][0:0]      we_m,
  input  logic [mst_c-1:0][a_w-1:0]  addr_m,
  input  logic [mst_c-1:0][31:0]     wdata_m,
  output logic [mst_c-1:0][0:0]      ack_m,
  output logic [mst_c-1:0][0:0]      err_m,
  output logic [31:0]                rdata_m,
  output logic [a_w-1:0]             paddr,
  output logic [31:0]                pwdata,
  output logic                       pwrite,
  output logic                       psel,
  output logic                       penable,
  input  logic [31:0]                prdata,
  input  logic                       pready
);

  apb_state_e       state_q, state_d;
  logic [mst_c-1:0] gnt_q, gnt_d;
  logic [a_w-1:0]   paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [mst_c-1:0] req_vec, arb_gnt;
  logic [a_w-1:0]   sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_we;
  logic             upd;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(tmo_c) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  apb_rr_arb #(.mst_c(mst_c)) u_rr (
    .clk_i     (pclk),
    .rst_ni    (presetn),
    .req_i     (req_vec),
    .upd_i     (upd),
    .upd_gnt_i (gnt_q),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    req_vec   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < mst_c; k++) begin
      req_vec[k] = req_m[k][0];
      if (arb_gnt[k]) begin
        sel_addr  = sel_addr | addr_m[k];
        sel_wdata = sel_wdata | wdata_m[k];
        sel_we    = sel_we | we_m[k][0];
      end
    end
  end

  // Grants are only taken in IDLE, so DONE gives the requester a cycle to drop req_m.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    upd      = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    ack_m    = '0;
    err_m    = '0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d  = SETUP;
          gnt_d    = arb_gnt;
          paddr_d  = sel_addr;
          pwdata_d = sel_wdata;
          pwrite_d = sel_we;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          rdata_d = pwrite_q ? 32'h0 : prdata;
          state_d = DONE;
`ifdef APB_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CW'(tmo_c - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      DONE: begin
        upd     = 1'b1;
        state_d = IDLE;
        for (int k = 0; k < mst_c; k++) begin
          ack_m[k] = gnt_q[k];
`ifdef APB_ARB_TIMEOUT_EN
          err_m[k] = gnt_q[k] & err_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign rdata_m = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb; timeout scenarios run only when
// APB_ARB_TIMEOUT_EN is defined for the build.
module tb_apb_master_arb;

  typedef struct {
    int          m;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [1:0][0:0] req_m = '0;
  logic [1:0][0:0] we_m = '0;
  logic [1:0][7:0] addr_m = '0;
  logic [1:0][31:0] wdata_m = '0;
  logic [1:0][0:0] ack_m;
  logic [1:0][0:0] err_m;
  logic [31:0]     rdata_m;
  logic [7:0]      paddr;
  logic [31:0]     pwdata;
  logic            pwrite, psel, penable;
  logic [31:0]     prdata;
  logic            pready = 1'b0;

  logic [31:0] slaveRdata = 32'h0;
  int          waitStates = 0;
  int          accCnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          ackCount = 0;
  int          accRun = 0;
  int          lastAccLen = 0;
  int          grantLog[$];
  exp_t        sbq[$];
  logic [1:0]  ackv, errv;

  assign ackv   = {ack_m[1][0], ack_m[0][0]};
  assign errv   = {err_m[1][0], err_m[0][0]};
  assign prdata = slaveRdata;

  apb_master_arb #(.mst_c(2), .a_w(8), .tmo_c(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .req_m   (req_m),
    .we_m    (we_m),
    .addr_m  (addr_m),
    .wdata_m (wdata_m),
    .ack_m   (ack_m),
    .err_m   (err_m),
    .rdata_m (rdata_m),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .prdata  (prdata),
    .pready  (pready)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata, input bit pushExp);
    exp_t e;
    we_m[m]    = we;
    addr_m[m]  = addr;
    wdata_m[m] = wdata;
    req_m[m]   = 1'b1;
    if (pushExp) begin
      e.m = m; e.we = we; e.addr = addr; e.wdata = wdata;
      e.rdata = we ? 32'h0 : slaveRdata;
      e.err = 1'b0;
      sbq.push_back(e);
    end
  endtask

  task automatic waitAcks(input int n, input int budget);
    int start;
    bit done;
    start = ackCount;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge pclk); #1;
      if (ackCount >= start + n) done = 1'b1;
    end
    if (!done) checkOutput("ack_wait_expired", ackCount - start, n);
  endtask

  task automatic waitAccess(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge pclk); #1;
      if (psel && penable) done = 1'b1;
    end
    if (!done) checkOutput("access_wait_expired", 0, 1);
  endtask

  // Slave model: pready rises on the ACCESS cycle after waitStates wait cycles.
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready = (accCnt >= waitStates);
      accCnt++;
    end else begin
      pready = 1'b0;
      accCnt = 0;
    end
  end

  // Monitor: bus fields against the head of the scoreboard, completions popped on ack.
  always @(negedge pclk) begin
    exp_t e;
    if (psel && sbq.size() > 0) begin
      checkOutput("paddr", {24'h0, paddr}, {24'h0, sbq[0].addr});
      checkOutput("pwrite", {31'h0, pwrite}, {31'h0, sbq[0].we});
      checkOutput("pwdata", pwdata, sbq[0].wdata);
    end
    if (psel && penable) accRun++;
    if (ackv != 2'b00) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_ack", {30'h0, ackv}, 32'h0);
      end else begin
        e = sbq.pop_front();
        checkOutput("ack_onehot", {30'h0, ackv}, 32'h1 << e.m);
        checkOutput("rdata_m", rdata_m, e.rdata);
        checkOutput("err_m", {30'h0, errv}, e.err ? (32'h1 << e.m) : 32'h0);
        grantLog.push_back(ackv[1] ? 1 : 0);
      end
      lastAccLen = accRun;
      ackCount++;
      accRun = 0;
    end
  end

  initial begin
    int base;
    int gl0;
    exp_t e;

    // Reset state
    repeat (2) @(negedge pclk);
    checkOutput("rst_psel", {31'h0, psel}, 0);
    checkOutput("rst_penable", {31'h0, penable}, 0);
    checkOutput("rst_pwrite", {31'h0, pwrite}, 0);
    checkOutput("rst_paddr", {24'h0, paddr}, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_ack", {30'h0, ackv}, 0);
    checkOutput("rst_err", {30'h0, errv}, 0);
    checkOutput("rst_rdata", rdata_m, 0);
    #1 presetn = 1'b1;

    // Single zero-wait read by master 0
    slaveRdata = 32'hDEADBEEF;
    waitStates = 0;
    @(negedge pclk); #1;
    applyStimulus(0, 1'b0, 8'h10, 32'h0000_0011, 1'b1);
    @(negedge pclk);
    checkOutput("rd_c1_psel", {31'h0, psel}, 1);
    checkOutput("rd_c1_penable", {31'h0, penable}, 0);
    @(negedge pclk);
    checkOutput("rd_c2_psel", {31'h0, psel}, 1);
    checkOutput("rd_c2_penable", {31'h0, penable}, 1);
    @(negedge pclk);
    checkOutput("rd_c3_ack", {30'h0, ackv}, 32'h1);
    checkOutput("rd_c3_rdata", rdata_m, 32'hDEADBEEF);
    checkOutput("rd_c3_psel", {31'h0, psel}, 0);
    #1 req_m[0] = 1'b0;
    @(negedge pclk);
    checkOutput("rd_c4_ack", {30'h0, ackv}, 0);
    #1;

    // Write by master 1 with two wait states
    waitStates = 2;
    applyStimulus(1, 1'b1, 8'h24, 32'h12345678, 1'b1);
    waitAcks(1, 20);
    req_m[1] = 1'b0;
    checkOutput("wr_access_len", lastAccLen, 3);
    @(negedge pclk);
    checkOutput("hold_paddr", {24'h0, paddr}, 32'h24);
    checkOutput("hold_pwrite", {31'h0, pwrite}, 1);
    checkOutput("hold_pwdata", pwdata, 32'h12345678);
    checkOutput("hold_psel", {31'h0, psel}, 0);
    #1;

    // Contention: both masters held high for four transfers
    waitStates = 1;
    slaveRdata = 32'hCAFE0001;
    gl0 = grantLog.size();
    applyStimulus(0, 1'b0, 8'h30, 32'h0000_0030, 1'b1);
    applyStimulus(1, 1'b1, 8'h40, 32'hA5A5A5A5, 1'b1);
    applyStimulus(0, 1'b0, 8'h30, 32'h0000_0030, 1'b1);
    applyStimulus(1, 1'b1, 8'h40, 32'hA5A5A5A5, 1'b1);
    waitAcks(4, 60);
    req_m = '0;
    if (grantLog.size() >= gl0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("rr_order", grantLog[gl0 + i], i % 2);
        if (i > 0) checkOutput("rr_no_repeat", grantLog[gl0 + i] == grantLog[gl0 + i - 1], 0);
      end
    end else begin
      checkOutput("rr_count", grantLog.size() - gl0, 4);
    end

    // Glitch request from master 1 during master 0 ACCESS
    waitStates = 3;
    slaveRdata = 32'h0BADF00D;
    @(negedge pclk); #1;
    base = ackCount;
    applyStimulus(0, 1'b0, 8'h50, 32'h0000_0050, 1'b1);
    waitAccess(10);
    applyStimulus(1, 1'b1, 8'h60, 32'h0000_0060, 1'b0);
    @(negedge pclk); #1;
    req_m[1] = 1'b0;
    waitAcks(1, 20);
    req_m[0] = 1'b0;
    repeat (6) @(negedge pclk);
    checkOutput("glitch_ack_count", ackCount - base, 1);
    checkOutput("glitch_psel", {31'h0, psel}, 0);
    #1;

    // Reset in the middle of a five-wait-state ACCESS by master 1
    waitStates = 5;
    base = ackCount;
    applyStimulus(1, 1'b0, 8'h70, 32'h0000_0070, 1'b0);
    waitAccess(10);
    repeat (2) @(negedge pclk);
    #1;
    presetn  = 1'b0;
    req_m[1] = 1'b0;
    @(negedge pclk);
    checkOutput("abort_psel", {31'h0, psel}, 0);
    checkOutput("abort_penable", {31'h0, penable}, 0);
    checkOutput("abort_ack", {30'h0, ackv}, 0);
    checkOutput("abort_paddr", {24'h0, paddr}, 0);
    @(negedge pclk); #1;
    presetn = 1'b1;
    checkOutput("abort_no_ack", ackCount - base, 0);
    waitStates = 0;
    slaveRdata = 32'h00C0FFEE;
    applyStimulus(0, 1'b0, 8'h80, 32'h0000_0080, 1'b1);
    applyStimulus(1, 1'b0, 8'h90, 32'h0000_0090, 1'b0);
    waitAcks(1, 20);
    req_m = '0;
    if (grantLog.size() > 0) checkOutput("post_reset_grant", grantLog[grantLog.size() - 1], 0);
    else checkOutput("post_reset_grant_seen", 0, 1);
    @(negedge pclk); #1;

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout with pready held low: error completion after 16 ACCESS cycles
    waitStates = 1000;
    slaveRdata = 32'h11112222;
    e.m = 0; e.we = 1'b0; e.addr = 8'hA0; e.wdata = 32'h0000_00A0;
    e.rdata = 32'h0; e.err = 1'b1;
    sbq.push_back(e);
    applyStimulus(0, 1'b0, 8'hA0, 32'h0000_00A0, 1'b0);
    waitAcks(1, 40);
    req_m[0] = 1'b0;
    checkOutput("tmo_access_len", lastAccLen, 16);
    @(negedge pclk); #1;

    // pready on the timeout cycle wins: normal completion
    waitStates = 15;
    applyStimulus(1, 1'b0, 8'hB0, 32'h0000_00B0, 1'b1);
    waitAcks(1, 40);
    req_m[1] = 1'b0;
    checkOutput("tmo_edge_access_len", lastAccLen, 16);
    @(negedge pclk); #1;
`endif

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The block SHALL have parameter mst_c, default 2, meaning the number of requesting masters (1..8).
REQ-002 The block SHALL have parameter a_w, default 8, meaning the APB address width.
REQ-003 The block SHALL have parameter tmo_c, default 16, meaning the ACCESS-phase timeout in cycles; it is used only with APB_ARB_TIMEOUT_EN.
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port presetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req_m, input, [mst_c-1:0][0:0]: per-master transfer request.
REQ-007 The block SHALL have port we_m, input, [mst_c-1:0][0:0]: per-master write enable (1 = write, 0 = read).
REQ-008 The block SHALL have port addr_m, input, [mst_c-1:0][a_w-1:0]: per-master address.
REQ-009 The block SHALL have port wdata_m, input, [mst_c-1:0][31:0]: per-master write data.
REQ-010 The block SHALL have port ack_m, output, [mst_c-1:0][0:0]: per-master one-cycle completion pulse.
REQ-011 The block SHALL have port err_m, output, [mst_c-1:0][0:0]: per-master error flag, valid while the matching ack_m is high.
REQ-012 The block SHALL have port rdata_m, output, [31:0]: read data shared by all masters, valid while an ack_m bit is high.
REQ-013 The block SHALL have APB master ports: paddr out [a_w-1:0], pwdata out [31:0], pwrite out 1, psel out 1, penable out 1, prdata in [31:0], pready in 1.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, SETUP, ACCESS and DONE.
REQ-015 In IDLE with any req_m bit high, the block SHALL grant one master by round-robin, searching from the index after the last granted master.
REQ-016 On a grant, the block SHALL register the granted master's addr, wdata and we, and go to SETUP.
REQ-017 In SETUP, the block SHALL drive psel=1 and penable=0, and SHALL go to ACCESS unconditionally after one cycle.
REQ-018 In ACCESS, the block SHALL drive psel=1 and penable=1, and SHALL hold paddr, pwdata and pwrite stable.
REQ-019 In ACCESS with pready=1, the block SHALL capture prdata (read only; otherwise capture 0) and go to DONE.
REQ-020 In DONE, the block SHALL assert ack_m[grant] for exactly one cycle, drive rdata_m from the captured value, and go to IDLE.
REQ-021 In DONE, the block SHALL make no new grant, so the requester has one cycle to drop req_m.
REQ-022 With a zero-wait-state slave, the minimum transfer SHALL be 4 cycles: grant decision, SETUP, ACCESS, DONE.
REQ-023 In IDLE and DONE, psel and penable SHALL be 0.
REQ-024 paddr, pwdata and pwrite SHALL hold their last values outside a transfer.
REQ-025 A req_m bit dropped by a master before its grant SHALL be ignored without side effects.
REQ-026 Changes on req_m, addr_m, wdata_m or we_m during SETUP or ACCESS SHALL NOT affect the transfer in progress.
REQ-027 When several req_m bits are high in IDLE, exactly one master SHALL be granted; with all bits held high, masters SHALL be served in strict rotation 0,1,...,mst_c-1,0.
REQ-028 The round-robin pointer SHALL update only when a transfer completes in DONE.

Reset
REQ-029 While presetn=0 at a rising edge, the block SHALL enter IDLE with psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, ack_m=0, err_m=0 and rdata_m=0.
REQ-030 On reset, the last-grant pointer SHALL be set to mst_c-1, so master 0 has first priority.
REQ-031 A reset during SETUP or ACCESS SHALL abort the transfer with no ack_m pulse.

Configuration
REQ-032 With macro APB_ARB_TIMEOUT_EN defined, a counter SHALL be cleared on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-033 With APB_ARB_TIMEOUT_EN defined, when that counter reaches tmo_c-1 with pready still 0, the block SHALL go to DONE with err_m[grant]=1 and rdata_m=0.
REQ-034 With APB_ARB_TIMEOUT_EN defined, if pready=1 occurs in the same cycle as the timeout, the block SHALL treat the transfer as a normal completion with err_m=0.
REQ-035 With APB_ARB_TIMEOUT_EN undefined, the block SHALL wait in ACCESS indefinitely, SHALL tie err_m to 0, and SHALL contain no counter logic.

Structure
REQ-036 Package apb_arb_pkg SHALL hold the FSM state enum typedef and the default constants for mst_c and tmo_c.
REQ-037 Sub-module apb_rr_arb SHALL contain the round-robin grant logic and the last-grant pointer: request vector in, one-hot grant out, update strobe in.
REQ-038 The block SHALL be usable directly in front of the existing APB address-decode mux.

Verification
REQ-039 Single read: req_m=2'b01, addr 8'h10, zero-wait slave returns 32'hDEADBEEF -> psel high cycles 1-2, penable high cycle 2, ack_m[0] high in cycle 3, rdata_m=32'hDEADBEEF.
REQ-040 Single write: master 1 writes 32'h12345678 to 8'h24, slave with 2 wait states -> pwrite=1, ACCESS lasts 3 cycles, one ack_m[1] pulse, err_m=0.
REQ-041 Contention: both req_m bits held high for 4 transfers -> grant order 0,1,0,1 and no back-to-back grant to one master.
REQ-042 Reset in ACCESS: presetn=0 during a 5-wait-state access -> next cycle psel=0, penable=0, no ack_m pulse; the first grant after reset goes to master 0.
REQ-043 Timeout (macro on, tmo_c=16): pready held 0 -> ack_m pulse with err_m=1 and rdata_m=0 after 16 ACCESS cycles; repeat with pready=1 on the timeout cycle -> err_m=0.
REQ-044 Glitch request: req_m[1] high for one cycle during master 0's ACCESS, then low -> no transfer issued for master 1.
